// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes,
// state encodings and datapath select codes.
package mips_multicycle_ctrl_pkg;

    // Opcode / funct values consumed from the instruction register
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Controller states; encoding 15 is never entered on purpose
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_TRAP   = 4'd14,
        S_UNUSED = 4'd15
    } state_t;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REG    = 2'd3;

    // Register write-data select
    localparam logic [1:0] MTR_ALUOUT = 2'd0;
    localparam logic [1:0] MTR_MDR    = 2'd1;
    localparam logic [1:0] MTR_PC     = 2'd2;

    // Register destination select
    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // True for states whose exit to FETCH finishes (retires) an instruction
    function automatic logic is_completing(input state_t s);
        case (s)
            S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB,
            S_BRANCH, S_JUMP, S_JAL, S_JR: is_completing = 1'b1;
            default:                       is_completing = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Combinational decode of the controller state into the datapath control word.
// Only the memory-ready qualifier and the bne flag modify the per-state word.
module mips_multicycle_ctrl_outdec
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic       reset,
    input  logic [3:0] state,
    input  logic       mem_ok,
    input  logic       is_bne,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source
);

    // Per-state control word; everything is forced quiet while reset is held
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = RD_RT;
        mem_to_reg    = MTR_ALUOUT;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        if (!reset) begin
            case (state_t'(state))
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = mem_ok;
                    pc_write  = mem_ok;
                    alu_src_b = SRCB_FOUR;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = MTR_MDR;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ALUWB: begin
                    reg_dst   = RD_RD;
                    reg_write = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_source     = PCS_ALUOUT;
                    pc_write_cond = 1'b1;
                    branch_ne     = is_bne;
                end
                S_JUMP: begin
                    pc_source = PCS_JUMP;
                    pc_write  = 1'b1;
                end
                S_JAL: begin
                    reg_dst    = RD_RA;
                    mem_to_reg = MTR_PC;
                    reg_write  = 1'b1;
                    pc_source  = PCS_JUMP;
                    pc_write   = 1'b1;
                end
                S_JR: begin
                    pc_source = PCS_REG;
                    pc_write  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// traps on unknown opcodes and counts retired instructions.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_count
);

    state_t           state_q;
    state_t           state_d;
    logic             mem_ok;
    logic             retire;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;

    // Without the handshake every memory state completes in a single cycle
    assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // Next-state selection, including opcode dispatch out of DECODE
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:       state_d = (funct == FN_JR) ? S_JR : S_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_TRAP:   state_d = S_TRAP;
            S_UNUSED: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // An instruction retires when a finishing state hands control back to FETCH
    assign retire = is_completing(state_q) && (state_d == S_FETCH);

    // State register, sticky trap flag and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign state         = state_q;
    assign illegal_op    = illegal_q;
    assign retired_count = count_q;

    mips_multicycle_ctrl_outdec u_outdec (
        .reset         (reset),
        .state         (state_q),
        .mem_ok        (mem_ok),
        .is_bne        (op == OP_BNE),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for the multi-cycle MIPS controller.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       illegal_op;
    logic [31:0] retired_count;

    logic       reset2;
    logic [5:0] op2;
    logic [5:0] funct2;
    logic       mem_ready2;
    logic       pc_write2, pc_write_cond2, branch_ne2, iord2, mem_read2, mem_write2, ir_write2, reg_write2, alu_src_a2;
    logic [1:0] reg_dst2, mem_to_reg2, alu_src_b2, alu_op2, pc_source2;
    logic [3:0] state2;
    logic       illegal_op2;
    logic [3:0] retired_count2;

    int compared = 0;
    int mismatched = 0;

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
        .retired_count(retired_count)
    );

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(0), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset2), .op(op2), .funct(funct2), .mem_ready(mem_ready2),
        .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .branch_ne(branch_ne2), .iord(iord2),
        .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2), .reg_dst(reg_dst2),
        .mem_to_reg(mem_to_reg2), .reg_write(reg_write2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
        .alu_op(alu_op2), .pc_source(pc_source2), .state(state2), .illegal_op(illegal_op2),
        .retired_count(retired_count2)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        op = 6'h23;
        funct = 6'h00;
        tick();
        compared++;
        if (state !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %0d expected 0", state);
        end
        compared++;
        if ({pc_write, mem_read, ir_write, mem_write, reg_write, pc_write_cond} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_strobes: got %b expected 000000",
                     {pc_write, mem_read, ir_write, mem_write, reg_write, pc_write_cond});
        end
        compared++;
        if (illegal_op !== 1'b0 || retired_count !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got illegal=%0d count=%0d expected 0/0", illegal_op, retired_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_lw_stall();
        int  exp_s [9] = '{0, 0, 0, 1, 2, 3, 3, 4, 0};
        bit  rdy   [9] = '{0, 0, 1, 1, 1, 0, 1, 1, 1};
        do_reset();
        op = 6'h23;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            #1;
            compared++;
            if (state !== 4'(exp_s[i])) begin
                mismatched++;
                $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            end
            if (i == 1) begin
                compared++;
                if (ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL lw_fetch_stall: got ir=%0d pc=%0d rd=%0d expected 0/0/1", ir_write, pc_write, mem_read);
                end
            end
            if (i == 2) begin
                compared++;
                if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL lw_fetch_ready: got ir=%0d pc=%0d expected 1/1", ir_write, pc_write);
                end
            end
            if (i == 5) begin
                compared++;
                if (mem_read !== 1'b1 || iord !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL lw_memrd: got rd=%0d iord=%0d expected 1/1", mem_read, iord);
                end
            end
            if (i == 7) begin
                compared++;
                if (reg_write !== 1'b1 || mem_to_reg !== 2'd1 || reg_dst !== 2'd0) begin
                    mismatched++;
                    $display("[TB] FAIL lw_memwb: got rw=%0d mtr=%0d dst=%0d expected 1/1/0", reg_write, mem_to_reg, reg_dst);
                end
            end
            if (i < 8) tick();
        end
        compared++;
        if (retired_count !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL lw_count: got %0d expected 1", retired_count);
        end
    endtask

    task automatic test_rtype_jr();
        int         exp_s [8] = '{0, 1, 6, 7, 0, 1, 13, 0};
        logic [5:0] fn    [8] = '{6'h20, 6'h20, 6'h20, 6'h20, 6'h08, 6'h08, 6'h08, 6'h08};
        do_reset();
        mem_ready = 1'b1;
        op = 6'h00;
        for (int i = 0; i < 8; i++) begin
            funct = fn[i];
            #1;
            compared++;
            if (state !== 4'(exp_s[i])) begin
                mismatched++;
                $display("[TB] FAIL rj_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            end
            if (i == 2) begin
                compared++;
                if (alu_op !== 2'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0) begin
                    mismatched++;
                    $display("[TB] FAIL r_exec: got op=%0d a=%0d b=%0d expected 2/1/0", alu_op, alu_src_a, alu_src_b);
                end
            end
            if (i == 3) begin
                compared++;
                if (reg_dst !== 2'd1 || reg_write !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL r_aluwb: got dst=%0d rw=%0d expected 1/1", reg_dst, reg_write);
                end
            end
            if (i == 6) begin
                compared++;
                if (pc_source !== 2'd3 || pc_write !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL jr_pc: got src=%0d pw=%0d expected 3/1", pc_source, pc_write);
                end
            end
            if (i < 7) tick();
        end
        compared++;
        if (retired_count !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL rj_count: got %0d expected 2", retired_count);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2] = '{6'h05, 6'h04};
        bit         ne  [2] = '{1'b1, 1'b0};
        do_reset();
        mem_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            op = ops[b];
            #1;
            compared++;
            if (state !== 4'd0) begin
                mismatched++;
                $display("[TB] FAIL br_fetch[%0d]: got %0d expected 0", b, state);
            end
            tick();
            compared++;
            if (state !== 4'd1 || alu_src_b !== 2'd3 || alu_op !== 2'd0) begin
                mismatched++;
                $display("[TB] FAIL br_decode[%0d]: got st=%0d b=%0d op=%0d expected 1/3/0", b, state, alu_src_b, alu_op);
            end
            tick();
            compared++;
            if (state !== 4'd8 || pc_write_cond !== 1'b1 || branch_ne !== ne[b] || alu_op !== 2'd1 ||
                pc_source !== 2'd1 || pc_write !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL br_exec[%0d]: got st=%0d pwc=%0d ne=%0d op=%0d src=%0d pw=%0d expected 8/1/%0d/1/1/0",
                         b, state, pc_write_cond, branch_ne, alu_op, pc_source, pc_write, ne[b]);
            end
            tick();
        end
        compared++;
        if (state !== 4'd0 || retired_count !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL br_end: got st=%0d count=%0d expected 0/2", state, retired_count);
        end
    endtask

    task automatic test_jal();
        do_reset();
        mem_ready = 1'b1;
        op = 6'h03;
        tick();
        tick();
        compared++;
        if (state !== 4'd12 || reg_dst !== 2'd2 || mem_to_reg !== 2'd2 || reg_write !== 1'b1 ||
            pc_write !== 1'b1 || pc_source !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL jal_word: got st=%0d dst=%0d mtr=%0d rw=%0d pw=%0d src=%0d expected 12/2/2/1/1/2",
                     state, reg_dst, mem_to_reg, reg_write, pc_write, pc_source);
        end
        tick();
        compared++;
        if (state !== 4'd0 || retired_count !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL jal_end: got st=%0d count=%0d expected 0/1", state, retired_count);
        end
    endtask

    task automatic test_trap();
        do_reset();
        mem_ready = 1'b1;
        op = 6'h3F;
        tick();
        compared++;
        if (state !== 4'd1 || illegal_op !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL trap_decode: got st=%0d ill=%0d expected 1/0", state, illegal_op);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            compared++;
            if (state !== 4'd14 || illegal_op !== 1'b1 || retired_count !== 32'd0 ||
                {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write} !== 6'b0) begin
                mismatched++;
                $display("[TB] FAIL trap_hold[%0d]: got st=%0d ill=%0d count=%0d strobes=%b expected 14/1/0/000000",
                         i, state, illegal_op, retired_count,
                         {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write});
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++;
        if (state !== 4'd0 || illegal_op !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL trap_reset: got st=%0d ill=%0d expected 0/0", state, illegal_op);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        mem_ready = 1'b1;
        op = 6'h02;
        tick();
        tick();
        tick();
        op = 6'h2B;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        compared++;
        if (state !== 4'd5 || mem_write !== 1'b1 || retired_count !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL sw_stall: got st=%0d wr=%0d count=%0d expected 5/1/1", state, mem_write, retired_count);
        end
        tick();
        compared++;
        if (state !== 4'd5 || retired_count !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL sw_hold: got st=%0d count=%0d expected 5/1", state, retired_count);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (mem_write !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL sw_reset_strobe: got %0d expected 0", mem_write);
        end
        tick();
        reset = 1'b0;
        compared++;
        if (state !== 4'd0 || retired_count !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL sw_reset_state: got st=%0d count=%0d expected 0/0", state, retired_count);
        end
    endtask

    task automatic test_wrap();
        reset2 = 1'b1;
        op2 = 6'h02;
        funct2 = 6'h00;
        mem_ready2 = 1'b0;
        tick();
        reset2 = 1'b0;
        #1;
        compared++;
        if (state2 !== 4'd0 || pc_write2 !== 1'b1 || ir_write2 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL nohs_fetch: got st=%0d pw=%0d ir=%0d expected 0/1/1", state2, pc_write2, ir_write2);
        end
        tick();
        tick();
        compared++;
        if (state2 !== 4'd9) begin
            mismatched++;
            $display("[TB] FAIL nohs_jump: got %0d expected 9", state2);
        end
        for (int i = 0; i < 43; i++) tick();
        compared++;
        if (retired_count2 !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL wrap_15: got %0d expected 15", retired_count2);
        end
        tick();
        tick();
        tick();
        compared++;
        if (retired_count2 !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL wrap_0: got %0d expected 0", retired_count2);
        end
    endtask

    initial begin
        reset = 1'b1;
        op = 6'h00;
        funct = 6'h00;
        mem_ready = 1'b1;
        reset2 = 1'b1;
        op2 = 6'h02;
        funct2 = 6'h00;
        mem_ready2 = 1'b0;
        test_reset();
        test_lw_stall();
        test_rtype_jr();
        test_branch();
        test_jal();
        test_trap();
        test_reset_mid_stall();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
